// File: rtl/bip2_pkg.sv
// Shared types, select encodings and branch helpers for the BIP2 control unit.
// Opcode values are fixed at five bits; the instruction/data width lives in the top's parameters.
package bip2_pkg;

   localparam int OPC_W = 5;

   typedef enum logic [OPC_W-1:0] {
      OP_HLT  = 5'd0,
      OP_STO  = 5'd1,
      OP_LD   = 5'd2,
      OP_LDI  = 5'd3,
      OP_ADD  = 5'd4,
      OP_ADDI = 5'd5,
      OP_SUB  = 5'd6,
      OP_SUBI = 5'd7,
      OP_BEQ  = 5'd8,
      OP_BNE  = 5'd9,
      OP_BGT  = 5'd10,
      OP_BGE  = 5'd11,
      OP_BLT  = 5'd12,
      OP_BLE  = 5'd13,
      OP_JMP  = 5'd14
   } opcode_t;

   typedef enum logic [2:0] {FETCH, DECODE, MEM, EXEC, HALT} cu_state_t;

   localparam logic [1:0] SEL_A_DATA = 2'b00;
   localparam logic [1:0] SEL_A_EXT  = 2'b01;
   localparam logic [1:0] SEL_A_ALU  = 2'b10;
   localparam logic       ALU_ADD    = 1'b0;
   localparam logic       ALU_SUB    = 1'b1;

   typedef struct packed {
      logic       req;
      logic [1:0] sel_a;
      logic       sel_b;
      logic       alu_op;
      logic       acc_wr;
      logic       status_wr;
      logic       data_rd;
      logic       data_wr;
      logic       halted;
   } ctrl_t;

   function automatic logic is_defined(input logic [OPC_W-1:0] op);
      return op <= OP_JMP;
   endfunction

   function automatic logic is_branch(input logic [OPC_W-1:0] op);
      return (op >= OP_BEQ) && (op <= OP_JMP);
   endfunction

   function automatic logic needs_mem(input logic [OPC_W-1:0] op);
      return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic branch_taken(input logic [OPC_W-1:0] op, input logic z, input logic n);
      logic t;
      case (op)
         OP_BEQ:  t = z;
         OP_BNE:  t = !z;
         OP_BGT:  t = !z && !n;
         OP_BGE:  t = !n;
         OP_BLT:  t = n;
         OP_BLE:  t = n || z;
         OP_JMP:  t = 1'b1;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/bip2_decoder.sv
// Combinational map from (state, opcode) to datapath/memory strobes; zero latency.
// The top feeds it next-state values so every strobe leaves the top registered.
module bip2_decoder
   import bip2_pkg::*;
(
   input  cu_state_t        state,
   input  logic [OPC_W-1:0] opcode,
   input  logic             fetch_en,
   output ctrl_t            ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH:  ctrl.req     = fetch_en;
         MEM:    ctrl.data_rd = 1'b1;
         HALT:   ctrl.halted  = 1'b1;
         EXEC: begin
            case (opcode)
               OP_STO: ctrl.data_wr = 1'b1;
               OP_LD: begin
                  ctrl.sel_a  = SEL_A_DATA;
                  ctrl.acc_wr = 1'b1;
               end
               OP_LDI: begin
                  ctrl.sel_a  = SEL_A_EXT;
                  ctrl.acc_wr = 1'b1;
               end
               OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                  ctrl.sel_a     = SEL_A_ALU;
                  ctrl.sel_b     = (opcode == OP_ADDI) || (opcode == OP_SUBI);
                  ctrl.alu_op    = ((opcode == OP_SUB) || (opcode == OP_SUBI)) ? ALU_SUB : ALU_ADD;
                  ctrl.acc_wr    = 1'b1;
                  ctrl.status_wr = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bip2_control_unit.sv
// BIP2 multi-cycle controller: FETCH/DECODE/[MEM]/EXEC, branch 2, imm 3, mem-operand 4 cycles; fetch stalls on instr_valid_in.
// Optional BIP2_CU_SINGLE_STEP_EN adds step_in: each pulse (remembered one deep) releases one fetch.
module bip2_control_unit
   import bip2_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int OPERAND_WIDTH = 11,
   parameter int OPCODE_WIDTH  = 5
) (
   input  logic                     clock_in,
   input  logic                     reset_in,
`ifdef BIP2_CU_SINGLE_STEP_EN
   input  logic                     step_in,
`endif
   output logic                     instr_req_out,
   output logic [OPERAND_WIDTH-1:0] instr_addr_out,
   input  logic                     instr_valid_in,
   input  logic [DATA_WIDTH-1:0]    instr_data_in,
   input  logic                     status_Z_in,
   input  logic                     status_N_in,
   output logic [OPERAND_WIDTH-1:0] operand_out,
   output logic [1:0]               sel_A_out,
   output logic                     sel_B_out,
   output logic                     alu_op_out,
   output logic                     acc_wr_out,
   output logic                     status_wr_out,
   output logic                     acc_reset_out,
   output logic                     status_reset_out,
   output logic                     data_rd_out,
   output logic                     data_wr_out,
   output logic                     halted_out,
   output logic                     illegal_out
);

   cu_state_t                 state, state_n;
   logic [OPERAND_WIDTH-1:0]  pc, pc_n;
   logic [DATA_WIDTH-1:0]     ir, ir_n;
   logic                      illegal, illegal_n;
   ctrl_t                     ctrl, ctrl_n, ctrl_rst;
   logic [OPCODE_WIDTH-1:0]   op, op_n;
   logic                      fetch_fire;
   logic                      fetch_en_n;

   assign op         = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
   assign op_n       = ir_n[DATA_WIDTH-1 -: OPCODE_WIDTH];
   assign fetch_fire = (state == FETCH) && ctrl.req && instr_valid_in;

`ifdef BIP2_CU_SINGLE_STEP_EN
   localparam logic RST_REQ = 1'b0;
   logic step_pend, step_pend_n;
   // A pulse landing in the same cycle a fetch completes stays pending for the next one.
   assign step_pend_n = (step_pend && !fetch_fire) || step_in;
   assign fetch_en_n  = step_pend_n;
`else
   localparam logic RST_REQ = 1'b1;
   assign fetch_en_n = 1'b1;
`endif

   always_comb begin
      state_n   = state;
      pc_n      = pc;
      ir_n      = ir;
      illegal_n = illegal;
      case (state)
         FETCH: begin
            if (fetch_fire) begin
               ir_n    = instr_data_in;
               pc_n    = pc + OPERAND_WIDTH'(1);
               state_n = DECODE;
            end
         end
         DECODE: begin
            if (!is_defined(op)) begin
               state_n   = HALT;
               illegal_n = 1'b1;
            end else if (op == OP_HLT) begin
               state_n = HALT;
            end else if (is_branch(op)) begin
               if (branch_taken(op, status_Z_in, status_N_in))
                  pc_n = ir[OPERAND_WIDTH-1:0];
               state_n = FETCH;
            end else if (needs_mem(op)) begin
               state_n = MEM;
            end else begin
               state_n = EXEC;
            end
         end
         MEM:     state_n = EXEC;
         EXEC:    state_n = FETCH;
         HALT:    state_n = HALT;
         default: state_n = FETCH;
      endcase
   end

   // Decoding the next state lets the strobes come straight from flops.
   bip2_decoder u_decoder (
      .state    (state_n),
      .opcode   (op_n),
      .fetch_en (fetch_en_n),
      .ctrl     (ctrl_n)
   );

   always_comb begin
      ctrl_rst     = '0;
      ctrl_rst.req = RST_REQ;
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state     <= FETCH;
         pc        <= '0;
         ir        <= '0;
         illegal   <= 1'b0;
         ctrl      <= ctrl_rst;
`ifdef BIP2_CU_SINGLE_STEP_EN
         step_pend <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         ir        <= ir_n;
         illegal   <= illegal_n;
         ctrl      <= ctrl_n;
`ifdef BIP2_CU_SINGLE_STEP_EN
         step_pend <= step_pend_n;
`endif
      end
   end

   assign instr_req_out    = ctrl.req;
   assign instr_addr_out   = pc;
   assign operand_out      = ir[OPERAND_WIDTH-1:0];
   assign sel_A_out        = ctrl.sel_a;
   assign sel_B_out        = ctrl.sel_b;
   assign alu_op_out       = ctrl.alu_op;
   assign acc_wr_out       = ctrl.acc_wr;
   assign status_wr_out    = ctrl.status_wr;
   assign data_rd_out      = ctrl.data_rd;
   assign data_wr_out      = ctrl.data_wr;
   assign halted_out       = ctrl.halted;
   assign illegal_out      = illegal;
   assign acc_reset_out    = reset_in;
   assign status_reset_out = reset_in;

endmodule

// File: tb/tb_bip2_control_unit.sv
// Directed bench: accumulator/memory model driven by the DUT strobes, fetch and write scoreboards.
`timescale 1ns/1ps
module tb_bip2_control_unit;
   import bip2_pkg::*;

   localparam int DW = 16;
   localparam int OW = 11;
`ifdef BIP2_CU_SINGLE_STEP_EN
   localparam logic RST_REQ = 1'b0;
`else
   localparam logic RST_REQ = 1'b1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_in = 1'b1;
   logic          instr_valid_in = 1'b0;
   logic [DW-1:0] instr_data_in = '0;
   logic          status_Z_in = 1'b0, status_N_in = 1'b0;
   logic          instr_req_out, sel_B_out, alu_op_out, acc_wr_out, status_wr_out;
   logic          acc_reset_out, status_reset_out, data_rd_out, data_wr_out, halted_out, illegal_out;
   logic [OW-1:0] instr_addr_out, operand_out;
   logic [1:0]    sel_A_out;
`ifdef BIP2_CU_SINGLE_STEP_EN
   logic          step_in = 1'b1;
`endif

   bip2_control_unit dut (
      .clock_in         (clk),
      .reset_in         (reset_in),
`ifdef BIP2_CU_SINGLE_STEP_EN
      .step_in          (step_in),
`endif
      .instr_req_out    (instr_req_out),
      .instr_addr_out   (instr_addr_out),
      .instr_valid_in   (instr_valid_in),
      .instr_data_in    (instr_data_in),
      .status_Z_in      (status_Z_in),
      .status_N_in      (status_N_in),
      .operand_out      (operand_out),
      .sel_A_out        (sel_A_out),
      .sel_B_out        (sel_B_out),
      .alu_op_out       (alu_op_out),
      .acc_wr_out       (acc_wr_out),
      .status_wr_out    (status_wr_out),
      .acc_reset_out    (acc_reset_out),
      .status_reset_out (status_reset_out),
      .data_rd_out      (data_rd_out),
      .data_wr_out      (data_wr_out),
      .halted_out       (halted_out),
      .illegal_out      (illegal_out)
   );

   typedef struct { logic [OW-1:0] addr; int gap; } fetch_t;
   typedef struct { logic [OW-1:0] addr; logic [DW-1:0] data; } wr_t;

   logic [DW-1:0] imem [0:2047];
   logic [DW-1:0] dmem [0:2047];
   fetch_t        fq[$];
   wr_t           wq[$];
   int            checks = 0, errors = 0;
   logic [DW-1:0] acc = '0, rd_data = '0;
   logic          zf = 1'b0, nf = 1'b0;
   int            cnum = 0, last_fetch = 0, fetch_wait = 0, wait_cnt = 0;
   logic [OW-1:0] held_addr = '0, held_opnd = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [4:0] op, input logic [OW-1:0] opnd);
      return {op, opnd};
   endfunction

   task automatic push_fetch(input logic [OW-1:0] addr, input int gap);
      fetch_t f;
      f.addr = addr; f.gap = gap;
      fq.push_back(f);
   endtask

   task automatic push_wr(input logic [OW-1:0] addr, input logic [DW-1:0] data);
      wr_t w;
      w.addr = addr; w.data = data;
      wq.push_back(w);
   endtask

   // One clock: observe strobes at the falling edge, update models, drive next inputs.
   task automatic cyc();
      logic [DW-1:0] b, res;
      fetch_t f;
      wr_t w;
      @(negedge clk);
      cnum++;
      b   = sel_B_out ? DW'(operand_out) : rd_data;
      res = alu_op_out ? acc - b : acc + b;
      if (acc_reset_out) acc = '0;
      if (status_reset_out) begin zf = 1'b0; nf = 1'b0; end
      instr_valid_in = 1'b0;
      if (!reset_in) begin
         if (acc_wr_out) begin
            case (sel_A_out)
               2'b00:   acc = rd_data;
               2'b01:   acc = DW'(operand_out);
               default: acc = res;
            endcase
         end
         if (status_wr_out) begin zf = (res == '0); nf = res[DW-1]; end
         if (data_rd_out) rd_data = dmem[operand_out];
         if (data_wr_out) begin
            check("write_expected", wq.size() > 0, 1);
            if (wq.size() > 0) begin
               w = wq.pop_front();
               check("write_addr", operand_out, w.addr);
               check("write_data", acc, w.data);
            end
            dmem[operand_out] = acc;
         end
         if (instr_req_out) begin
            if (wait_cnt > 0) begin
               check("req_addr_held", instr_addr_out, held_addr);
               check("ir_held", operand_out, held_opnd);
            end else begin
               held_addr = instr_addr_out;
               held_opnd = operand_out;
            end
            if (wait_cnt >= fetch_wait) begin
               check("fetch_expected", fq.size() > 0, 1);
               if (fq.size() > 0) begin
                  f = fq.pop_front();
                  check("fetch_addr", instr_addr_out, f.addr);
                  if (f.gap > 0) check("fetch_gap", cnum - last_fetch, f.gap);
               end
               last_fetch     = cnum;
               instr_valid_in = 1'b1;
               instr_data_in  = imem[instr_addr_out];
               wait_cnt       = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
      status_Z_in = zf;
      status_N_in = nf;
   endtask

   task automatic do_reset();
      reset_in = 1'b1;
      cyc();
      reset_in = 1'b0;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 2048; i++) imem[i] = mk(OP_HLT, '0);
   endtask

   task automatic run_prog(input string tag, input int budget);
      int i;
      i = 0;
      while (halted_out !== 1'b1 && i < budget) begin cyc(); i++; end
      check({tag, "_halted"}, halted_out, 1);
      check({tag, "_fetch_drained"}, fq.size(), 0);
      check({tag, "_write_drained"}, wq.size(), 0);
   endtask

   initial begin
      int i;
      clear_imem();
      for (int k = 0; k < 2048; k++) dmem[k] = '0;

      // Reset state
      do_reset();
      reset_in = 1'b1;
      cyc();
      check("rst_req", instr_req_out, RST_REQ);
      check("rst_addr", instr_addr_out, 0);
      check("rst_halted", halted_out, 0);
      check("rst_illegal", illegal_out, 0);
      check("rst_strobes", {data_rd_out, data_wr_out, acc_wr_out, status_wr_out}, 0);
      check("rst_acc_reset", acc_reset_out, 1);
      check("rst_status_reset", status_reset_out, 1);
      reset_in = 1'b0;

      // LDI 5, ADDI 3, STO 0x010
      imem[0] = mk(OP_LDI, 11'd5); imem[1] = mk(OP_ADDI, 11'd3);
      imem[2] = mk(OP_STO, 11'h010); imem[3] = mk(OP_HLT, '0);
      push_fetch(0, 0); push_fetch(1, 3); push_fetch(2, 3); push_fetch(3, 3);
      push_wr(11'h010, 16'd8);
      run_prog("ldi_addi_sto", 40);
      check("acc_eq_8", acc, 8);
      check("hlt_not_illegal", illegal_out, 0);
      cyc(); cyc(); cyc();
      check("halt_no_req", instr_req_out, 0);
      check("halt_stays", halted_out, 1);

      // BEQ taken after LDI 4, SUBI 4
      clear_imem(); do_reset();
      imem[0] = mk(OP_LDI, 11'd4); imem[1] = mk(OP_SUBI, 11'd4);
      imem[2] = mk(OP_BEQ, 11'h020); imem[11'h020] = mk(OP_HLT, '0);
      push_fetch(0, 0); push_fetch(1, 3); push_fetch(2, 3); push_fetch(11'h020, 2);
      run_prog("beq_taken", 40);
      check("beq_z", zf, 1);

      // BNE not taken after the same sequence
      clear_imem(); do_reset();
      imem[0] = mk(OP_LDI, 11'd4); imem[1] = mk(OP_SUBI, 11'd4);
      imem[2] = mk(OP_BNE, 11'h020); imem[11'h020] = mk(OP_LDI, 11'd1);
      push_fetch(0, 0); push_fetch(1, 3); push_fetch(2, 3); push_fetch(3, 2);
      run_prog("bne_not_taken", 40);

      // Negative result: BLT taken, BGT not taken, BLE taken
      clear_imem(); do_reset();
      imem[0] = mk(OP_LDI, 11'd1); imem[1] = mk(OP_SUBI, 11'd2);
      imem[2] = mk(OP_BLT, 11'h040); imem[11'h040] = mk(OP_BGT, 11'h050);
      imem[11'h041] = mk(OP_BLE, 11'h060); imem[11'h050] = mk(OP_LDI, 11'd9);
      push_fetch(0, 0); push_fetch(1, 3); push_fetch(2, 3);
      push_fetch(11'h040, 2); push_fetch(11'h041, 2); push_fetch(11'h060, 2);
      run_prog("neg_branches", 40);
      check("neg_n", nf, 1);

      // Memory-operand ops: LD 5, ADD 5, STO 6, SUB 5, STO 7
      clear_imem(); do_reset();
      dmem[5] = 16'd7;
      imem[0] = mk(OP_LD, 11'd5); imem[1] = mk(OP_ADD, 11'd5); imem[2] = mk(OP_STO, 11'd6);
      imem[3] = mk(OP_SUB, 11'd5); imem[4] = mk(OP_STO, 11'd7);
      push_fetch(0, 0); push_fetch(1, 4); push_fetch(2, 4);
      push_fetch(3, 3); push_fetch(4, 4); push_fetch(5, 3);
      push_wr(11'd6, 16'd14); push_wr(11'd7, 16'd7);
      run_prog("mem_ops", 60);

      // Fetch held 3 cycles per instruction
      clear_imem(); do_reset();
      fetch_wait = 3;
      imem[0] = mk(OP_LDI, 11'd9); imem[1] = mk(OP_STO, 11'h011);
      push_fetch(0, 0); push_fetch(1, 6); push_fetch(2, 6);
      push_wr(11'h011, 16'd9);
      run_prog("fetch_wait", 60);
      fetch_wait = 0;

      // Undefined opcode halts and sticks; reset recovers
      clear_imem(); do_reset();
      imem[0] = 16'hF800;
      push_fetch(0, 0);
      run_prog("illegal_op", 20);
      check("illegal_set", illegal_out, 1);
      cyc(); cyc(); cyc();
      check("illegal_no_req", instr_req_out, 0);
      check("illegal_sticky", illegal_out, 1);
      imem[0] = mk(OP_HLT, '0);
      do_reset();
      check("recover_addr", instr_addr_out, 0);
      check("recover_illegal", illegal_out, 0);
      push_fetch(0, 0);
      run_prog("recover", 20);

      // PC wrap: BNE to 0x7FF, SUBI 0 sets Z, refetch from 0
      clear_imem(); do_reset();
      imem[0] = mk(OP_BNE, 11'h7FF); imem[11'h7FF] = mk(OP_SUBI, 11'd0);
      push_fetch(0, 0); push_fetch(11'h7FF, 2); push_fetch(0, 3); push_fetch(1, 2);
      run_prog("pc_wrap", 40);

      // Reset during MEM: no accumulator write, fetch restarts at 0
      clear_imem(); do_reset();
      dmem[5] = 16'd7;
      imem[0] = mk(OP_LD, 11'd5);
      push_fetch(0, 0);
      i = 0;
      while (data_rd_out !== 1'b1 && i < 10) begin cyc(); i++; end
      check("mem_reached", data_rd_out, 1);
      reset_in = 1'b1;
      push_fetch(0, 0);
      cyc();
      reset_in = 1'b0;
      check("midrst_no_acc_wr", acc_wr_out, 0);
      check("midrst_addr", instr_addr_out, 0);
      check("midrst_acc", acc, 0);
      cyc();
      check("midrst_no_acc_wr2", acc_wr_out, 0);
      push_fetch(1, 4);
      run_prog("midrst", 40);
      check("midrst_ld_acc", acc, 7);

`ifdef BIP2_CU_SINGLE_STEP_EN
      // One fetch per step pulse
      clear_imem();
      step_in = 1'b0;
      do_reset();
      imem[0] = mk(OP_LDI, 11'd1); imem[1] = mk(OP_LDI, 11'd2);
      for (int k = 0; k < 4; k++) cyc();
      check("step_idle_no_req", instr_req_out, 0);
      push_fetch(0, 0);
      step_in = 1'b1; cyc(); step_in = 1'b0;
      for (int k = 0; k < 6; k++) cyc();
      check("step_one_fetch", fq.size(), 0);
      check("step_wait_req", instr_req_out, 0);
      check("step_wait_addr", instr_addr_out, 1);
      push_fetch(1, 0);
      step_in = 1'b1; cyc(); step_in = 1'b0;
      for (int k = 0; k < 6; k++) cyc();
      check("step_second_fetch", fq.size(), 0);
      step_in = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
